piso_tx: RTL and testbench

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a load strobe and shifts it out one bit per clock, with a complementary output and busy/done status. It sits in the sequential-circuits library as the transmit end of the serial bit stream that our latch/flip-flop capture stages sample. It is the unit that drives a serial-in receiver.

---
 rtl/piso_tx.sv | 77 +++++++
 tb/tb_piso_tx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with busy/done status
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             sout,
    output logic             soutbar,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n, shifted;
    logic [CW-1:0]    cnt, cnt_n;
    logic             sout_n, busy_n, done_n;

    assign ready   = ~busy;
    assign soutbar = ~sout;
    assign shifted = MSB_FIRST ? sreg << 1 : sreg >> 1;

    // next-state: accept in IDLE, shift one bit per edge, leave the edge after done
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        sout_n  = sout;
        busy_n  = busy;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (load) begin
                state_n = SHIFT;
                sreg_n  = din;
                cnt_n   = CW'(1);
                sout_n  = MSB_FIRST ? din[WIDTH-1] : din[0];
                busy_n  = 1'b1;
            end
        end else if (cnt == CW'(WIDTH)) begin
            state_n = IDLE;
            sreg_n  = '0;
            cnt_n   = '0;
            sout_n  = 1'b0;
            busy_n  = 1'b0;
        end else begin
            sreg_n = shifted;
            cnt_n  = cnt + 1'b1;
            sout_n = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
            done_n = cnt == CW'(WIDTH - 1);
        end
    end

    // state and output registers; reset overrides load and any word in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            sout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
            sout  <= sout_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: checks MSB-first and LSB-first piso_tx against a timeline model
module tb_piso_tx;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] din = '0;
    logic         m_ready, m_sout, m_soutbar, m_busy, m_done;
    logic         l_ready, l_sout, l_soutbar, l_busy, l_done;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .load(load), .din(din), .ready(m_ready),
        .sout(m_sout), .soutbar(m_soutbar), .busy(m_busy), .done(m_done)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .load(load), .din(din), .ready(l_ready),
        .sout(l_sout), .soutbar(l_soutbar), .busy(l_busy), .done(l_done)
    );

    typedef struct {
        logic         r;
        logic         l;
        logic [W-1:0] d;
        logic         s;
        logic         b;
        logic         dn;
    } vec_t;

    int           tests = 0;
    int           fails = 0;
    int           phase = -1;
    int           ndone = 0;
    logic [W-1:0] word = '0;
    logic         em, el;
    vec_t         tbl[12];

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // phase = bits already on the wire minus one; -1 means idle
    task automatic step(input logic r, input logic l, input logic [W-1:0] d);
        rst  = r;
        load = l;
        din  = d;
        @(posedge clk);
        if (r) phase = -1;
        else if (phase < 0) begin
            if (l) begin
                phase = 0;
                word  = d;
            end
        end else begin
            phase++;
            if (phase == W) phase = -1;
        end
        #1;
        if (m_done) ndone++;
        em = (phase >= 0) ? word[W-1-phase] : 1'b0;
        el = (phase >= 0) ? word[phase] : 1'b0;
        chk("m_busy", m_busy, phase >= 0);
        chk("m_ready", m_ready, phase < 0);
        chk("m_sout", m_sout, em);
        chk("m_soutbar", m_soutbar, ~em);
        chk("m_done", m_done, phase == W - 1);
        chk("l_busy", l_busy, phase >= 0);
        chk("l_ready", l_ready, phase < 0);
        chk("l_sout", l_sout, el);
        chk("l_soutbar", l_soutbar, ~el);
        chk("l_done", l_done, phase == W - 1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].l, tbl[i].d);
            chk("tbl_sout", m_sout, tbl[i].s);
            chk("tbl_soutbar", m_soutbar, ~tbl[i].s);
            chk("tbl_busy", m_busy, tbl[i].b);
            chk("tbl_ready", m_ready, ~tbl[i].b);
            chk("tbl_done", m_done, tbl[i].dn);
            chk("tbl_lsb_sout", l_sout, tbl[i].s);
        end
        // load while busy is ignored
        ndone = 0;
        step(1'b0, 1'b1, 8'h3C);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
        chk("busy_load_one_done", ndone == 1, 1'b1);
        step(1'b0, 1'b1, 8'hFF);
        chk("ff_bit", m_sout, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 8'h00);
            chk("ff_bit", m_sout, 1'b1);
        end
        step(1'b0, 1'b0, 8'h00);
        chk("ff_end_ready", m_ready, 1'b1);
        // reset mid-word aborts without a done pulse
        ndone = 0;
        step(1'b0, 1'b1, 8'hF0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("abort_sout", m_sout, 1'b0);
        chk("abort_busy", m_busy, 1'b0);
        for (int i = 0; i < W + 2; i++) step(1'b0, 1'b0, 8'h00);
        chk("abort_no_done", ndone == 0, 1'b1);
        step(1'b0, 1'b1, 8'h81);
        for (int i = 0; i < W; i++) step(1'b0, 1'b0, 8'h00);
        chk("after_abort_one_done", ndone == 1, 1'b1);
        // simultaneous reset and load
        step(1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00);
            chk("rst_load_busy", m_busy, 1'b0);
            chk("rst_load_sout", m_sout, 1'b0);
        end
        // random traffic against the model
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, W'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
